countdown_scheduler: RTL
========================

# countdown_scheduler

Job sequencer directly upstream of the preset down-counter. Accepts delay jobs (3-bit delay plus tag) over a valid/ready handshake into a small FIFO. Drives the counter's `en`/`val` inputs to run each job in order, and watches the counter's `count` output for completion. Emits one `done` pulse per job, carrying the job's tag, so downstream logic can chain timed events without managing the counter directly.

## Interface
- `DEPTH`, 4: job FIFO entries (power of two, ≥2)
- `TAG_W`, 4: tag width
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: job offered
- `in_ready` out 1: job accepted when `in_valid && in_ready` at a clock edge
- `in_delay` in 3: job delay value
- `in_tag` in TAG_W: job tag
- `cancel` in 1: abort the job currently in progress
- `cnt_en` out 1: to counter `en`; 1 = count down, 0 = load
- `cnt_val` out 3: to counter `val`
- `cnt_count` in 4: from counter `count`
- `done` out 1: one-cycle job-finished pulse
- `done_tag` out TAG_W: tag of the finished job, valid while `done`=1
- `done_cancelled` out 1: 1 if the finished job was aborted
- `level` out $clog2(DEPTH)+1: FIFO occupancy
- `busy` out 1: state ≠ IDLE

## Operation
- FIFO
  - Push on handshake.
  - Pop only when a job finishes (normal completion or cancel).
  - The head entry stays in the FIFO while its job runs.
  - `in_ready` = `level` < DEPTH, from registered `level`. A push is not allowed into a full FIFO, even in a cycle where a pop also occurs.
  - A simultaneous push and pop leaves `level` unchanged.
- FSM states and outputs
  - IDLE: `cnt_en`=0, `cnt_val`=0, so the counter holds 0.
  - LOAD: `cnt_en`=0, `cnt_val`=head delay, so the counter loads the delay on the next edge.
  - RUN: `cnt_en`=1, `cnt_val`=0.
- FSM transitions
  - IDLE→LOAD when `level`>0.
  - LOAD→RUN unconditionally.
  - RUN with `cnt_count`==0:
    - Completion.
    - Pop the FIFO.
    - Set `done`=1, `done_tag`=head tag, `done_cancelled`=0.
    - Next state is LOAD if `level`>1, else IDLE.
  - LOAD or RUN with `cancel`=1 (and not completing):
    - Pop the FIFO.
    - Set `done`=1, `done_tag`=head tag, `done_cancelled`=1.
    - Next state is IDLE, even if more jobs are queued. IDLE picks them up on the following cycle.
  - Completion has priority over `cancel` in the same cycle.
  - `cancel` in IDLE is ignored.
- Output sourcing
  - `cnt_en` and `cnt_val` are decoded only from the state register and the FIFO head register.
  - There is no combinational path from any input to any output.
- Width rules
  - Any nonzero `cnt_count` (including values 8–15) means running.
  - `in_delay` is zero-extended by the counter, not here.
- Reset (synchronous)
  - FIFO emptied and state set to IDLE.
  - `cnt_en`=0, `cnt_val`=0, `done`=0, `done_tag`=0, `done_cancelled`=0, `level`=0, `busy`=0.
  - `in_ready`=0 while `rst`=1, and 1 on the first cycle after.
  - Reset mid-job discards all queued jobs with no `done`.

## Timing
- Accept edge E0 into an empty FIFO with the FSM in IDLE:
  - E1: LOAD.
  - E2: RUN, counter = d.
  - RUN sees `cnt_count` d … 0 (d+1 cycles).
  - E(d+3): `done` rises, high for exactly one cycle.
- Back-to-back jobs: the next LOAD starts at the completion edge, so job k+1's `done` comes dk+1+2 edges after job k's `done`.
- Delay 0: `done` at E3.
- Cancel sampled high in the cycle before edge Ec: `done` (cancelled) and IDLE at Ec. The counter reloads 0 at Ec+1.
- `in_ready` recovers one cycle after the pop edge that frees space.

## Test plan
- Reset: hold `rst` 2 cycles, release.
  - During reset: `in_ready`=0.
  - After release: `cnt_en`=0, `cnt_val`=0, `done`=0, `level`=0, `in_ready`=1.
- Single job, delay=5, tag=0xA, accepted at E0:
  - LOAD with `cnt_val`=5 at E1; `cnt_en`=1 from E2.
  - `done`=1 with `done_tag`=0xA, `done_cancelled`=0 at E8 only.
  - `busy`=0 after E8.
- Delay=0, tag=3:
  - `done` at E3, tag 3.
  - Exactly one RUN cycle with `cnt_count`=0.
- Overflow: hold `in_valid` with delays 2,1,0,3,4 and tags 1–5.
  - Four accepted; `in_ready`=0 at `level`=4.
  - Fifth accepted after the first completion.
  - `done_tag` order 1,2,3,4,5 with spacing 4,3,2,5,6 edges.
- Cancel: delay=7, tag=9; pulse `cancel` when `cnt_count`=3.
  - Next edge: `done`=1, `done_tag`=9, `done_cancelled`=1, IDLE, `cnt_en`=0.
  - Queued job 2 loads one cycle later.
- Reset mid-RUN with 2 jobs queued:
  - No `done`; `level`=0, `cnt_en`=0 after the reset edge.
  - A new job accepted afterwards completes with correct timing.

Source files
------------

// File: rtl/countdown_scheduler.sv
// Job sequencer in front of a preset down-counter: queues delay jobs in a small
// FIFO, drives the counter's load/count controls and reports each finished job.
module countdown_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_delay,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     cancel,
  output logic                     cnt_en,
  output logic [2:0]               cnt_val,
  input  logic [3:0]               cnt_count,
  output logic                     done,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     done_cancelled,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Handshake: a job transfers on any rising edge where in_valid && in_ready;
  // in_ready is registered and never depends on in_valid in the same cycle.

  logic [1:0]       r_state;
  logic [2:0]       r_delay_mem [DEPTH];
  logic [TAG_W-1:0] r_tag_mem   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_in_ready;
  logic             r_done;
  logic [TAG_W-1:0] r_done_tag;
  logic             r_done_cancelled;

  logic             w_push;
  logic             w_complete;
  logic             w_cancel;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;
  logic [1:0]       w_state_nxt;
  logic [2:0]       w_head_delay;
  logic [TAG_W-1:0] w_head_tag;

  assign w_head_delay = r_delay_mem[r_rd_ptr];
  assign w_head_tag   = r_tag_mem[r_rd_ptr];

  assign w_push     = in_valid && r_in_ready;
  // Any nonzero count, including 8..15, means the counter is still running.
  assign w_complete = (r_state == ST_RUN) && (cnt_count == 4'd0);
  assign w_cancel   = ((r_state == ST_LOAD) || (r_state == ST_RUN)) && cancel && !w_complete;
  assign w_pop      = w_complete || w_cancel;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = w_cancel ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (w_complete) begin
          w_state_nxt = (r_level > LW'(1)) ? ST_LOAD : ST_IDLE;
        end else if (w_cancel) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_delay_mem[r_wr_ptr] <= in_delay;
      r_tag_mem[r_wr_ptr]   <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_in_ready       <= 1'b0;
      r_done           <= 1'b0;
      r_done_tag       <= '0;
      r_done_cancelled <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level          <= w_level_nxt;
      r_in_ready       <= (w_level_nxt < LW'(DEPTH));
      r_done           <= w_pop;
      r_done_tag       <= w_pop ? w_head_tag : '0;
      r_done_cancelled <= w_cancel;
    end
  end

  assign cnt_en         = (r_state == ST_RUN);
  assign cnt_val        = (r_state == ST_LOAD) ? w_head_delay : 3'd0;
  assign in_ready       = r_in_ready;
  assign done           = r_done;
  assign done_tag       = r_done_tag;
  assign done_cancelled = r_done_cancelled;
  assign level          = r_level;
  assign busy           = (r_state != ST_IDLE);
  assign dbg_state      = r_state;

endmodule
